// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow flags and full-with-simultaneous-read acceptance.
// Optional build macro: FIFO_FWFT_EN selects first-word-fall-through output
// (combinational head word); undefined gives a registered dout with 1-cycle
// read latency.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB is the wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic                  r_overflow, r_underflow;

  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_full, w_empty;
  logic                  w_rd_acc, w_wr_acc;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  // A read on a full FIFO frees a slot, so a same-cycle write still lands.
  // On an empty FIFO there is no bypass: the read is rejected.
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  assign count        = w_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (w_count >= AF_L);
  assign almost_empty = (w_count <= AE_L);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage write; contents survive flush and reset by design.
  always_ff @(posedge clk) begin
    if (!clr && w_wr_acc)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  // Pointer advance and sticky error flags; flush beats any same-cycle request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc)           r_wr_ptr    <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc)           r_rd_ptr    <= r_rd_ptr + PTR_ONE;
      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; meaningless while empty.
  assign dout = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  // Registered read port: loads on an accepted read, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_dout <= '0;
    else if (clr)      r_dout <= '0;
    else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end

  assign dout = r_dout;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed + randomized bench for fifo_sync_flags (default parameters),
// checked against a queue-based reference model.
module tb_fifo_sync_flags;
  localparam int DW = 8, AW = 4, DEPTH = 16, AF = 12, AE = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, " count"}, 32'(count), 32'(n));
    chk({tag, " empty"}, 32'(empty), 32'(n == 0));
    chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n > 0) chk({tag, " dout"}, 32'(dout), 32'(q[0]));
`else
    chk({tag, " dout"}, 32'(dout), 32'(m_dout));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
  endtask

  // Called at a negedge: drive, update model, clock, check at next negedge.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd,
                       input logic c, input string tag);
    bit ra, wa;
    wr_en = wr; din = d; rd_en = rd; clr = c;
    if (c) model_reset();
    else begin
      ra = rd && (q.size() > 0);
      wa = wr && ((q.size() < DEPTH) || ra);
      if (rd && !ra) m_udf = 1'b1;
      if (wr && !wa) m_ovf = 1'b1;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // 1. reset state
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // 2. fill 0x00..0x0F then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    // 3. full with simultaneous write/read, then write alone
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, "full_wr_rd");
    cycle(1'b1, 8'hBB, 1'b0, 1'b0, "full_wr_only");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "read_empty");

    // 4. empty with simultaneous write/read
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "empty_wr_rd");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "read_55");

    // 5. wrap-around around count 8
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "wrap_pre");
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, "wrap");
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

    // 6a. clr with write at count 7
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "pre_clr");
    cycle(1'b1, 8'h00, 1'b0, 1'b1, "clr_with_wr");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "after_clr_rd");

    // 6b. async reset mid-burst
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_rst");
    m_ovf = m_ovf; // flags already tracked by model
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_rd");
    wr_en = 1'b1; din = 8'h99;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    wr_en = 1'b0;
    check_all("rst_held");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("rst_release");

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 2), "random");
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
